// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: drives the next PC into an enable-less PC register, issues
// single-outstanding word fetches over req/ack and buffers results in a 2-entry FIFO.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Pc,
  output logic [31:0] NextPc,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRdata,
  input  logic        Redirect,
  input  logic [31:0] RedirectPc,
  output logic [31:0] Instr,
  output logic [31:0] InstrPc,
  output logic        InstrValid,
  input  logic        DecReady
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } state_t;

  state_t      state, state_nxt;
  logic        req_nxt;
  logic [31:0] addr_nxt;

  // FIFO: slot 0 is the head and doubles as the Instr/InstrPc/InstrValid outputs
  logic [31:0] instr_nxt, instr_pc_nxt;
  logic        valid_nxt;
  logic [31:0] tail_instr, tail_pc, tail_instr_nxt, tail_pc_nxt;
  logic        tail_valid, tail_valid_nxt;

  logic        xfer, pop, push, room;
  logic [31:0] redirect_target;

  assign xfer            = ImemReq & ImemAck;
  assign pop             = InstrValid & DecReady;
  assign room            = ~tail_valid | pop;
  assign redirect_target = {RedirectPc[31:2], 2'b00};

  // Next-state, request, next-PC and FIFO update
  always_comb begin
    state_nxt      = state;
    req_nxt        = ImemReq;
    addr_nxt       = ImemAddr;
    push           = 1'b0;
    NextPc         = Pc;
    instr_nxt      = Instr;
    instr_pc_nxt   = InstrPc;
    valid_nxt      = InstrValid;
    tail_instr_nxt = tail_instr;
    tail_pc_nxt    = tail_pc;
    tail_valid_nxt = tail_valid;

    case (state)
      IDLE: begin
        state_nxt = FETCH;
        if (Redirect) NextPc = redirect_target;
      end
      FETCH: begin
        if (Redirect) begin
          NextPc = redirect_target;
          if (ImemReq && !ImemAck) state_nxt = DISCARD;
          else                     req_nxt   = 1'b0;
        end else if (xfer) begin
          NextPc  = Pc + 32'd4;
          push    = 1'b1;
          req_nxt = 1'b0;
        end else if (!ImemReq && room) begin
          req_nxt  = 1'b1;
          addr_nxt = Pc;
        end
      end
      DISCARD: begin
        if (Redirect) NextPc = redirect_target;
        if (ImemAck) begin
          req_nxt   = 1'b0;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase

    if (Redirect) begin
      valid_nxt      = 1'b0;
      tail_valid_nxt = 1'b0;
    end else if (pop) begin
      instr_nxt      = tail_instr;
      instr_pc_nxt   = tail_pc;
      valid_nxt      = tail_valid;
      tail_valid_nxt = 1'b0;
      if (push) begin
        if (tail_valid) begin
          tail_instr_nxt = ImemRdata;
          tail_pc_nxt    = ImemAddr;
          tail_valid_nxt = 1'b1;
        end else begin
          instr_nxt    = ImemRdata;
          instr_pc_nxt = ImemAddr;
          valid_nxt    = 1'b1;
        end
      end
    end else if (push) begin
      if (InstrValid) begin
        tail_instr_nxt = ImemRdata;
        tail_pc_nxt    = ImemAddr;
        tail_valid_nxt = 1'b1;
      end else begin
        instr_nxt    = ImemRdata;
        instr_pc_nxt = ImemAddr;
        valid_nxt    = 1'b1;
      end
    end

    // Reset wins over everything so the PC register loads the boot address
    if (!Reset_n) NextPc = RESET_PC;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      ImemReq    <= 1'b0;
      ImemAddr   <= 32'd0;
      Instr      <= 32'd0;
      InstrPc    <= 32'd0;
      InstrValid <= 1'b0;
      tail_instr <= 32'd0;
      tail_pc    <= 32'd0;
      tail_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      ImemReq    <= req_nxt;
      ImemAddr   <= addr_nxt;
      Instr      <= instr_nxt;
      InstrPc    <= instr_pc_nxt;
      InstrValid <= valid_nxt;
      tail_instr <= tail_instr_nxt;
      tail_pc    <= tail_pc_nxt;
      tail_valid <= tail_valid_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: plays the PC register and instruction memory, compares
// against a transaction-level model every cycle, plus directed literal checks.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MEM_KEY  = 32'hA5A5_0F0F;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic [31:0] Pc;
  logic [31:0] NextPc;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRdata;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPc = 32'd0;
  logic [31:0] Instr;
  logic [31:0] InstrPc;
  logic        InstrValid;
  logic        DecReady = 1'b1;

  logic ack_mode = 1'b1;
  logic ack_force = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Pc(Pc), .NextPc(NextPc),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemRdata(ImemRdata),
    .Redirect(Redirect), .RedirectPc(RedirectPc),
    .Instr(Instr), .InstrPc(InstrPc), .InstrValid(InstrValid), .DecReady(DecReady)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // PC register (no enable, no reset) and a memory returning a keyed word per address
  always @(posedge Clk) Pc <= NextPc;
  assign ImemAck   = ack_mode ? ImemReq : ack_force;
  assign ImemRdata = ImemAddr ^ MEM_KEY;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: one outstanding fetch, a queue toward decode, a model PC
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  bit          m_started = 0;
  bit          m_out = 0;
  bit          m_discard = 0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_nxt;
  bit          m_xfer, m_pop;
  ent_t        m_ent;

  function automatic logic [31:0] exp_next();
    if (!Reset_n) return RESET_PC;
    if (Redirect) return RedirectPc & 32'hFFFF_FFFC;
    if (m_out && !m_discard && ImemAck) return m_pc + 32'd4;
    return m_pc;
  endfunction

  always @(negedge Reset_n) begin
    m_started = 0;
    m_out     = 0;
    m_discard = 0;
    q.delete();
  end

  always @(posedge Clk) begin
    if (!Reset_n) begin
      m_pc = RESET_PC;
      m_started = 0;
      m_out = 0;
      m_discard = 0;
      q.delete();
    end else begin
      m_nxt  = exp_next();
      m_xfer = m_out && ImemAck;
      m_pop  = (q.size() > 0) && DecReady;
      if (!m_started) begin
        m_started = 1;
      end else if (Redirect) begin
        q.delete();
        if (m_xfer) begin
          m_out = 0;
          m_discard = 0;
        end else if (m_out) begin
          m_discard = 1;
        end
      end else if (m_discard) begin
        if (m_xfer) begin
          m_out = 0;
          m_discard = 0;
        end
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_xfer) begin
          m_ent.instr = m_addr ^ MEM_KEY;
          m_ent.pc    = m_addr;
          q.push_back(m_ent);
          m_out = 0;
        end else if (!m_out && q.size() < 2) begin
          m_out  = 1;
          m_addr = m_pc;
        end
      end
      m_pc = m_nxt;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge Clk) begin
    chk("ImemReq", 32'(ImemReq), 32'(m_out));
    if (m_out) chk("ImemAddr", ImemAddr, m_addr);
    chk("InstrValid", 32'(InstrValid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("Instr", Instr, q[0].instr);
      chk("InstrPc", InstrPc, q[0].pc);
    end
    chk("NextPc", NextPc, exp_next());
    if (Reset_n) chk("Pc", Pc, m_pc);
    else begin
      chk("rst_ImemAddr", ImemAddr, 32'd0);
      chk("rst_Instr", Instr, 32'd0);
      chk("rst_InstrPc", InstrPc, 32'd0);
    end
  end

  task automatic wait_req(output logic [31:0] a, output int at);
    bit found;
    found = 0;
    a = 32'd0;
    at = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      if (ImemReq) begin
        found = 1;
        a = ImemAddr;
        at = cyc;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_req: no request within 40 cycles, required one (cycle %0d)", cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] a;
  int          at, prev_at;
  logic [31:0] exp_addr [3];

  initial begin
    exp_addr[0] = 32'h0;
    exp_addr[1] = 32'h4;
    exp_addr[2] = 32'h8;

    // Reset then continuous fetch
    #1 Reset_n = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      chk("reset_NextPc", NextPc, 32'h0);
      chk("reset_ImemReq", 32'(ImemReq), 32'd0);
      chk("reset_InstrValid", 32'(InstrValid), 32'd0);
    end
    @(posedge Clk); #1 Reset_n = 1'b1;
    prev_at = 0;
    for (int k = 0; k < 3; k++) begin
      wait_req(a, at);
      chk("seq_addr", a, exp_addr[k]);
      if (k > 0) chk("seq_spacing", 32'(at - prev_at), 32'd2);
      prev_at = at;
      @(negedge Clk);
      chk("seq_valid", 32'(InstrValid), 32'd1);
      chk("seq_InstrPc", InstrPc, exp_addr[k]);
    end

    // Backpressure: fill both entries, then one pop releases one request
    @(posedge Clk); #1 DecReady = 1'b0;
    repeat (10) @(negedge Clk);
    chk("bp_req", 32'(ImemReq), 32'd0);
    chk("bp_valid", 32'(InstrValid), 32'd1);
    chk("bp_head", InstrPc, 32'hC);
    chk("bp_hold", NextPc, 32'h14);
    @(posedge Clk); #1 DecReady = 1'b1;
    @(posedge Clk); #1 DecReady = 1'b0;
    @(negedge Clk);
    chk("bp_newreq", 32'(ImemReq), 32'd1);
    chk("bp_newaddr", ImemAddr, 32'h14);
    chk("bp_popped", InstrPc, 32'h10);

    // Redirect with an outstanding, unacked request at 0x10
    @(posedge Clk); #1 Redirect = 1'b1; RedirectPc = 32'h8;
    @(posedge Clk); #1 Redirect = 1'b0;
    repeat (8) @(posedge Clk);
    #1 ack_mode = 1'b0; DecReady = 1'b1;
    @(posedge Clk); #1 DecReady = 1'b0;
    @(negedge Clk);
    chk("rd_req", 32'(ImemReq), 32'd1);
    chk("rd_addr", ImemAddr, 32'h10);
    chk("rd_head", InstrPc, 32'hC);
    @(posedge Clk); #1 Redirect = 1'b1; RedirectPc = 32'h103;
    @(negedge Clk);
    chk("rd_nextpc", NextPc, 32'h100);
    @(posedge Clk); #1 Redirect = 1'b0;
    @(negedge Clk);
    chk("rd_flushed", 32'(InstrValid), 32'd0);
    chk("rd_req_held", 32'(ImemReq), 32'd1);
    chk("rd_addr_held", ImemAddr, 32'h10);
    repeat (2) @(posedge Clk);
    #1 ack_force = 1'b1;
    @(negedge Clk);
    chk("rd_discard_hold", NextPc, 32'h100);
    @(posedge Clk); #1 ack_force = 1'b0; ack_mode = 1'b1;
    @(negedge Clk);
    chk("rd_dropped", 32'(InstrValid), 32'd0);
    wait_req(a, at);
    chk("rd_target", a, 32'h100);

    // Redirect coincident with ack and pop
    @(posedge Clk); #1;
    @(posedge Clk); #1 Redirect = 1'b1; RedirectPc = 32'h200; DecReady = 1'b1;
    @(negedge Clk);
    chk("co_req", 32'(ImemReq), 32'd1);
    chk("co_addr", ImemAddr, 32'h104);
    chk("co_head", InstrPc, 32'h100);
    chk("co_nextpc", NextPc, 32'h200);
    @(posedge Clk); #1 Redirect = 1'b0;
    @(negedge Clk);
    chk("co_empty", 32'(InstrValid), 32'd0);
    chk("co_noreq", 32'(ImemReq), 32'd0);
    wait_req(a, at);
    chk("co_target", a, 32'h200);

    // Wrap-around at the top of the address space
    @(posedge Clk); #1 Redirect = 1'b1; RedirectPc = 32'hFFFF_FFFC;
    @(posedge Clk); #1 Redirect = 1'b0;
    wait_req(a, at);
    chk("wrap_addr", a, 32'hFFFF_FFFC);
    chk("wrap_nextpc", NextPc, 32'h0);
    wait_req(a, at);
    chk("wrap_next", a, 32'h0);

    // Async reset in the middle of a handshake
    @(posedge Clk); #1 ack_mode = 1'b0; DecReady = 1'b0;
    wait_req(a, at);
    chk("ar_addr", a, 32'h4);
    chk("ar_valid_before", 32'(InstrValid), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("ar_req_drop", 32'(ImemReq), 32'd0);
    chk("ar_valid_drop", 32'(InstrValid), 32'd0);
    chk("ar_nextpc", NextPc, RESET_PC);
    ack_force = 1'b1;
    repeat (2) @(posedge Clk);
    #1 ack_force = 1'b0; ack_mode = 1'b1;
    @(posedge Clk); #1 Reset_n = 1'b1; DecReady = 1'b1;
    wait_req(a, at);
    chk("ar_restart", a, RESET_PC);
    @(negedge Clk);
    chk("ar_valid", 32'(InstrValid), 32'd1);
    chk("ar_instr", Instr, 32'hA5A5_0F0F);

    repeat (2) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
